// File: rtl/address_seq_if.sv
// Request/grant and address-latch control bundle for address_seq.
// Sequencer side is slave; requester/latch side is master.
interface address_seq_if;
  logic        req_fetch;
  logic        req_blk;
  logic        blk_dir;
  logic [15:0] blk_len;
  logic        req_rfsh;
  logic        gnt_fetch;
  logic        gnt_blk;
  logic        gnt_rfsh;
  logic        done;
  logic        blk_last;
  logic        blk_active;
  logic [15:0] blk_remaining;
  logic        ctl_al_we;
  logic        ctl_apin_mux;
  logic        ctl_apin_mux2;
  logic        ctl_bus_inc_oe;
  logic        ctl_inc_dec;
  logic        ctl_inc_limit6;
  logic        ctl_inc_cy;

  modport master (
    output req_fetch, req_blk, blk_dir, blk_len, req_rfsh,
    input  gnt_fetch, gnt_blk, gnt_rfsh, done, blk_last,
    input  blk_active, blk_remaining,
    input  ctl_al_we, ctl_apin_mux, ctl_apin_mux2,
    input  ctl_bus_inc_oe, ctl_inc_dec, ctl_inc_limit6,
    input  ctl_inc_cy
  );

  modport slave (
    input  req_fetch, req_blk, blk_dir, blk_len, req_rfsh,
    output gnt_fetch, gnt_blk, gnt_rfsh, done, blk_last,
    output blk_active, blk_remaining,
    output ctl_al_we, ctl_apin_mux, ctl_apin_mux2,
    output ctl_bus_inc_oe, ctl_inc_dec, ctl_inc_limit6,
    output ctl_inc_cy
  );
endinterface

// File: rtl/address_seq.sv
// Address sequencer: arbitrates fetch/block/refresh, drives latch controls.
// Define ADDRSEQ_RR_EN for round-robin block/fetch; default is fixed priority.
module address_seq (
  input  logic           clk,
  input  logic           reset,
  address_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    DRIVE,
    WB
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_FETCH,
    SEL_BLK,
    SEL_RFSH
  } sel_t;

  state_t      state_q;
  state_t      state_d;
  sel_t        sel;
  logic        any_req;
  logic        take;
  logic        blk_wins;
  logic        gnt_fetch_q;
  logic        gnt_blk_q;
  logic        gnt_rfsh_q;
  logic        blk_active_q;
  logic [15:0] blk_rem_q;
  logic        dir_q;
  logic        wb_blk;
  logic        last_wb;
  logic        blk_start;

  assign any_req = bus.req_fetch | bus.req_blk | bus.req_rfsh;

`ifdef ADDRSEQ_RR_EN
  logic prefer_blk_q;

  assign blk_wins = bus.req_blk & (~bus.req_fetch | prefer_blk_q);

  // Pointer flips toward whichever of block/fetch was not just granted
  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_blk_q <= 1'b0;
    end else if (take && sel == SEL_FETCH) begin
      prefer_blk_q <= 1'b1;
    end else if (take && sel == SEL_BLK) begin
      prefer_blk_q <= 1'b0;
    end
  end
`else
  assign blk_wins = bus.req_blk;
`endif

  // Winner select: refresh always first, then block/fetch
  always_comb begin
    sel = SEL_NONE;
    if (bus.req_rfsh) begin
      sel = SEL_RFSH;
    end else if (blk_wins) begin
      sel = SEL_BLK;
    end else if (bus.req_fetch) begin
      sel = SEL_FETCH;
    end
  end

  // Next-state: a new access can start from IDLE or straight out of WB
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          take    = 1'b1;
          state_d = LATCH;
        end
      end
      LATCH: state_d = DRIVE;
      DRIVE: state_d = WB;
      WB: begin
        if (any_req) begin
          take    = 1'b1;
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants latch at access start and hold until the access ends
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_fetch_q <= 1'b0;
      gnt_blk_q   <= 1'b0;
      gnt_rfsh_q  <= 1'b0;
    end else if (take) begin
      gnt_fetch_q <= (sel == SEL_FETCH);
      gnt_blk_q   <= (sel == SEL_BLK);
      gnt_rfsh_q  <= (sel == SEL_RFSH);
    end else if (state_q == WB) begin
      gnt_fetch_q <= 1'b0;
      gnt_blk_q   <= 1'b0;
      gnt_rfsh_q  <= 1'b0;
    end
  end

  assign wb_blk    = (state_q == WB) & gnt_blk_q;
  assign last_wb   = wb_blk & (blk_rem_q == 16'd1);
  assign blk_start = take & (sel == SEL_BLK) &
                     (~blk_active_q | last_wb);

  // Block run tracking; a new run may start on the edge the old one ends
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_active_q <= 1'b0;
      blk_rem_q    <= 16'h0000;
      dir_q        <= 1'b0;
    end else begin
      if (take && sel == SEL_BLK) begin
        dir_q <= bus.blk_dir;
      end
      if (wb_blk) begin
        blk_rem_q <= blk_rem_q - 16'd1;
        if (blk_rem_q == 16'd1) begin
          blk_active_q <= 1'b0;
        end
      end
      if (blk_start) begin
        blk_rem_q    <= bus.blk_len;
        blk_active_q <= 1'b1;
      end
    end
  end

  // Address-latch controls decoded from the access phase
  always_comb begin
    bus.ctl_al_we      = 1'b0;
    bus.ctl_apin_mux   = 1'b0;
    bus.ctl_apin_mux2  = 1'b0;
    bus.ctl_bus_inc_oe = 1'b0;
    bus.ctl_inc_dec    = 1'b0;
    bus.ctl_inc_limit6 = 1'b0;
    bus.ctl_inc_cy     = 1'b0;
    bus.done           = 1'b0;
    unique case (state_q)
      LATCH: bus.ctl_al_we = 1'b1;
      DRIVE: bus.ctl_apin_mux2 = 1'b1;
      WB: begin
        bus.ctl_bus_inc_oe = 1'b1;
        bus.ctl_inc_cy     = 1'b1;
        bus.done           = 1'b1;
        bus.ctl_inc_dec    = gnt_blk_q & dir_q;
        bus.ctl_inc_limit6 = gnt_rfsh_q;
      end
      default: ;
    endcase
  end

  assign bus.gnt_fetch     = gnt_fetch_q;
  assign bus.gnt_blk       = gnt_blk_q;
  assign bus.gnt_rfsh      = gnt_rfsh_q;
  assign bus.blk_last      = last_wb;
  assign bus.blk_active    = blk_active_q;
  assign bus.blk_remaining = blk_rem_q;

endmodule

// File: tb/tb_address_seq.sv
// Directed self-checking bench for address_seq.
// Outputs sampled on the falling edge; inputs changed there too.
module tb_address_seq;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total;

  address_seq_if bus ();

  address_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [11:0] GF  = 12'h800;
  localparam logic [11:0] GB  = 12'h400;
  localparam logic [11:0] GR  = 12'h200;
  localparam logic [11:0] LS  = 12'h080;
  localparam logic [11:0] AL  = 12'h040;
  localparam logic [11:0] MX2 = 12'h010;
  localparam logic [11:0] DEC = 12'h004;
  localparam logic [11:0] L6  = 12'h002;
  localparam logic [11:0] W   = 12'h109;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] obs();
    return {bus.gnt_fetch, bus.gnt_blk, bus.gnt_rfsh,
            bus.done, bus.blk_last, bus.ctl_al_we,
            bus.ctl_apin_mux, bus.ctl_apin_mux2,
            bus.ctl_bus_inc_oe, bus.ctl_inc_dec,
            bus.ctl_inc_limit6, bus.ctl_inc_cy};
  endfunction

  function automatic logic [16:0] blk_st();
    return {bus.blk_active, bus.blk_remaining};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.req_fetch = 1'b0;
    bus.req_blk   = 1'b0;
    bus.req_rfsh  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (obs() !== 12'h000)
      $display("FAIL reset_outs got %h want %h", obs(), 12'h000);
    else pass_cnt++;
    total++;
    if (blk_st() !== 17'h0)
      $display("FAIL reset_blk got %h want %h", blk_st(), 17'h0);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    bus.req_fetch = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== (GF | AL))
      $display("FAIL fetch_latch got %h want %h", obs(), GF | AL);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (obs() !== (GF | MX2))
      $display("FAIL fetch_drive got %h want %h", obs(), GF | MX2);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (obs() !== (GF | W))
      $display("FAIL fetch_wb got %h want %h", obs(), GF | W);
    else pass_cnt++;
    bus.req_fetch = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== 12'h000)
      $display("FAIL fetch_idle got %h want %h", obs(), 12'h000);
    else pass_cnt++;
  endtask

  task automatic test_block();
    logic [11:0] e;
    do_reset();
    bus.blk_dir = 1'b1;
    bus.blk_len = 16'd3;
    bus.req_blk = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (obs() !== (GB | AL))
        $display("FAIL blk_latch%0d got %h want %h", i, obs(), GB | AL);
      else pass_cnt++;
      total++;
      if (blk_st() !== {1'b1, 16'(3 - i)})
        $display("FAIL blk_rem%0d got %h want %h", i, blk_st(),
                 {1'b1, 16'(3 - i)});
      else pass_cnt++;
      @(negedge clk);
      total++;
      if (obs() !== (GB | MX2))
        $display("FAIL blk_drive%0d got %h want %h", i, obs(), GB | MX2);
      else pass_cnt++;
      @(negedge clk);
      e = GB | W | DEC | ((i == 2) ? LS : 12'h000);
      total++;
      if (obs() !== e)
        $display("FAIL blk_wb%0d got %h want %h", i, obs(), e);
      else pass_cnt++;
      if (i == 2) bus.req_blk = 1'b0;
    end
    @(negedge clk);
    total++;
    if (obs() !== 12'h000)
      $display("FAIL blk_idle got %h want %h", obs(), 12'h000);
    else pass_cnt++;
    total++;
    if (blk_st() !== 17'h0)
      $display("FAIL blk_end got %h want %h", blk_st(), 17'h0);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [11:0] e2;
    logic [16:0] es;
`ifdef ADDRSEQ_RR_EN
    e2 = GF | AL;
    es = 17'h0;
`else
    e2 = GB | AL;
    es = {1'b1, 16'd1};
`endif
    do_reset();
    bus.blk_len   = 16'd2;
    bus.blk_dir   = 1'b0;
    bus.req_rfsh  = 1'b1;
    bus.req_blk   = 1'b1;
    bus.req_fetch = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== (GR | AL))
      $display("FAIL pri_rfsh_latch got %h want %h", obs(), GR | AL);
    else pass_cnt++;
    bus.req_rfsh = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== (GR | MX2))
      $display("FAIL pri_rfsh_drive got %h want %h", obs(), GR | MX2);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (obs() !== (GR | W | L6))
      $display("FAIL pri_rfsh_wb got %h want %h", obs(), GR | W | L6);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (obs() !== e2)
      $display("FAIL pri_second got %h want %h", obs(), e2);
    else pass_cnt++;
    bus.req_blk   = 1'b0;
    bus.req_fetch = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (obs() !== 12'h000)
      $display("FAIL pri_idle got %h want %h", obs(), 12'h000);
    else pass_cnt++;
    total++;
    if (blk_st() !== es)
      $display("FAIL pri_blk got %h want %h", blk_st(), es);
    else pass_cnt++;
  endtask

  task automatic test_resume();
    do_reset();
    bus.blk_len = 16'd3;
    bus.blk_dir = 1'b0;
    bus.req_blk = 1'b1;
    @(negedge clk);
    total++;
    if (blk_st() !== {1'b1, 16'd3})
      $display("FAIL res_load got %h want %h", blk_st(), {1'b1, 16'd3});
    else pass_cnt++;
    bus.req_blk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (blk_st() !== {1'b1, 16'd2})
      $display("FAIL res_frozen got %h want %h", blk_st(), {1'b1, 16'd2});
    else pass_cnt++;
    bus.blk_len = 16'd9;
    bus.req_blk = 1'b1;
    @(negedge clk);
    total++;
    if ({obs(), blk_st()} !== {GB | AL, 1'b1, 16'd2})
      $display("FAIL res_noreload got %h want %h", {obs(), blk_st()},
               {GB | AL, 1'b1, 16'd2});
    else pass_cnt++;
    bus.req_blk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (blk_st() !== {1'b1, 16'd1})
      $display("FAIL res_after got %h want %h", blk_st(), {1'b1, 16'd1});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] eg [4];
`ifdef ADDRSEQ_RR_EN
    eg = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    eg = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    bus.blk_len   = 16'd4;
    bus.blk_dir   = 1'b0;
    bus.req_fetch = 1'b1;
    bus.req_blk   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({obs() & (GF | GB | AL)} !== {eg[i], 4'b0001, 6'b0})
        $display("FAIL b2b_grant%0d got %h want %h", i,
                 obs() & (GF | GB | AL), {eg[i], 4'b0001, 6'b0});
      else pass_cnt++;
      @(negedge clk);
      @(negedge clk);
      if (i == 3) begin
        bus.req_fetch = 1'b0;
        bus.req_blk   = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (obs() !== 12'h000)
      $display("FAIL b2b_idle got %h want %h", obs(), 12'h000);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.blk_len = 16'd0;
    bus.blk_dir = 1'b0;
    bus.req_blk = 1'b1;
    @(negedge clk);
    total++;
    if (blk_st() !== {1'b1, 16'h0000})
      $display("FAIL mid_load got %h want %h", blk_st(), {1'b1, 16'h0});
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (obs() !== (GB | W))
      $display("FAIL mid_wb got %h want %h", obs(), GB | W);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (blk_st() !== {1'b1, 16'hFFFF})
      $display("FAIL mid_wrap got %h want %h", blk_st(), {1'b1, 16'hFFFF});
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (obs() !== (GB | MX2))
      $display("FAIL mid_drive got %h want %h", obs(), GB | MX2);
    else pass_cnt++;
    reset       = 1'b1;
    bus.req_blk = 1'b0;
    @(negedge clk);
    total++;
    if ({obs(), blk_st()} !== 29'h0)
      $display("FAIL mid_reset got %h want %h", {obs(), blk_st()}, 29'h0);
    else pass_cnt++;
    reset       = 1'b0;
    bus.req_blk = 1'b1;
    @(negedge clk);
    total++;
    if ({obs(), blk_st()} !== {GB | AL, 1'b1, 16'h0000})
      $display("FAIL mid_restart got %h want %h", {obs(), blk_st()},
               {GB | AL, 1'b1, 16'h0});
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    bus.req_blk = 1'b0;
    @(negedge clk);
    total++;
    if ({obs(), blk_st()} !== {12'h000, 1'b1, 16'hFFFF})
      $display("FAIL mid_reload got %h want %h", {obs(), blk_st()},
               {12'h000, 1'b1, 16'hFFFF});
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt      = 0;
    total         = 0;
    reset         = 1'b1;
    bus.req_fetch = 1'b0;
    bus.req_blk   = 1'b0;
    bus.req_rfsh  = 1'b0;
    bus.blk_dir   = 1'b0;
    bus.blk_len   = 16'd0;
    test_reset();
    test_fetch();
    test_block();
    test_priority();
    test_resume();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
